// File: rtl/w_fir_folded.sv
// ---------------------------------------------------------------------------
// w_fir_folded -- time-multiplexed 2-bit-code FIR for the W filter path.
//
// N taps are folded over K = N/P cycles on P lane multipliers. Each product is
// a signed level looked up by {x[0]^w[0], x[1], w[1]}, scaled by
// SHIFT = R_OUT - R_W, accumulated at OUT_W + clog2(N) bits and saturated to
// OUT_W bits. Latency is K+2 cycles from acceptance; one sample per K+2 cycles.
// Parameter constraints: N must be a multiple of P, and R_OUT >= R_W.
//
// Optional feature macro: W_FOLD_BANK_SWAP_EN
//   defined   : live + shadow weight banks; writes go to shadow, swap_in
//               requests an exchange performed on an idle, non-accepting edge.
//   undefined : single live bank, swap_in is ignored.
//
// Ports
//   clock           in   the only clock
//   reset           in   asynchronous, active-high
//   valid_data_in   in   sample offered
//   data_in   [1:0] in   sample code
//   ready_in        out  block can accept a sample (IDLE and not in reset)
//   valid_update_in in   weight write strobe
//   update_idx      in   tap index for the write (>= N is ignored)
//   update_data     in   weight code
//   swap_in         in   bank-swap request (bank macro only)
//   valid_out       out  one-cycle result strobe
//   data_out        out  saturated signed result, held until the next result
//   sat_out         out  data_out was clipped, held with data_out
// ---------------------------------------------------------------------------
module w_fir_folded #(
    parameter int N     = 1008,
    parameter int P     = 8,
    parameter int W_W   = 8,
    parameter int R_W   = 6,
    parameter int OUT_W = 32,
    parameter int R_OUT = 28,
    parameter int LV0   = 0,
    parameter int LV1   = 1,
    parameter int LV2   = 2,
    parameter int LV3   = 3,
    parameter int LV4   = 4,
    parameter int LV5   = 5,
    parameter int LV6   = 6,
    parameter int LV7   = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid_data_in,
    input  logic [1:0]              data_in,
    output logic                    ready_in,
    input  logic                    valid_update_in,
    input  logic [$clog2(N)-1:0]    update_idx,
    input  logic [1:0]              update_data,
    input  logic                    swap_in,
    output logic                    valid_out,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    sat_out
);
    localparam int K     = N / P;
    localparam int SHIFT = R_OUT - R_W;
    localparam int IDX_W = $clog2(N);
    localparam int ACC_W = OUT_W + IDX_W;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    localparam logic signed [W_W-1:0] LUT [8] = '{
        W_W'(LV0), W_W'(LV1), W_W'(LV2), W_W'(LV3),
        W_W'(LV4), W_W'(LV5), W_W'(LV6), W_W'(LV7)
    };
    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              x_q [N];
    logic [1:0]              w_live [N];
    logic signed [ACC_W-1:0] acc_q, acc_d, grp_sum;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q;
    logic signed [OUT_W-1:0] data_q, data_d;
    logic                    sat_q, sat_d;
    logic [ACC_W-OUT_W:0]    acc_hi;
    logic                    ovf;
    logic                    accept;
    logic                    wr_ok;

`ifdef W_FOLD_BANK_SWAP_EN
    logic [1:0] w_q [2][N];
    logic       bank_q;     // index of the live bank
    logic       pend_q;
    logic       do_swap;
`else
    logic [1:0] w_q [N];
    logic       unused_swap;
    assign unused_swap = swap_in;
`endif

    // Scaled, sign-extended product for one tap.
    function automatic logic signed [ACC_W-1:0] prod(input logic [1:0] x, input logic [1:0] w);
        logic signed [W_W-1:0] lv;
        lv = LUT[{x[0] ^ w[0], x[1], w[1]}];
        return {{(ACC_W-W_W){lv[W_W-1]}}, lv} <<< SHIFT;
    endfunction

    assign ready_in = (state_q == IDLE) && !reset;
    assign accept   = valid_data_in && ready_in;
    assign wr_ok    = valid_update_in && (32'(update_idx) < 32'(N));

    always_comb begin
        for (int i = 0; i < N; i++) begin
`ifdef W_FOLD_BANK_SWAP_EN
            w_live[i] = w_q[bank_q][i];
`else
            w_live[i] = w_q[i];
`endif
        end
    end

    // Sum of the P products of the tap group selected by cnt_q.
    always_comb begin
        grp_sum = '0;
        for (int j = 0; j < P; j++) begin
            grp_sum = grp_sum + prod(x_q[IDX_W'(int'(cnt_q) * P + j)],
                                     w_live[IDX_W'(int'(cnt_q) * P + j)]);
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: a default assignment on entry keeps every comb output driven on
        // all paths, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(K - 1)) state_d = SAT;
            SAT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fits in OUT_W bits iff the bits from OUT_W-1 upward are all equal.
    assign acc_hi = acc_q[ACC_W-1:OUT_W-1];
    assign ovf    = !((&acc_hi) || (acc_hi == '0));

    // Datapath next-state.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        sat_d  = sat_q;
        unique case (state_q)
            IDLE: if (accept) begin
                acc_d = '0;
                cnt_d = '0;
            end
            RUN: begin
                acc_d = acc_q + grp_sum;
                cnt_d = cnt_q + 1'b1;
            end
            SAT: begin
                data_d = ovf ? (acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX) : acc_q[OUT_W-1:0];
                sat_d  = ovf;
            end
            default: ;
        endcase
    end

`ifdef W_FOLD_BANK_SWAP_EN
    // Swap only between samples so a computation never mixes weight sets.
    assign do_swap = (pend_q || swap_in) && (state_q == IDLE) && !accept;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            // NOTE: the tap and weight stores are plain flops and must start
            // from a known zero state, so they are cleared in the reset branch.
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
`ifdef W_FOLD_BANK_SWAP_EN
                w_q[0][i] <= '0;
                w_q[1][i] <= '0;
`else
                w_q[i] <= '0;
`endif
            end
`ifdef W_FOLD_BANK_SWAP_EN
            bank_q <= 1'b0;
            pend_q <= 1'b0;
`endif
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_q == SAT);
            data_q  <= data_d;
            sat_q   <= sat_d;
            if (accept) begin
                x_q[0] <= data_in;
                for (int i = 1; i < N; i++) x_q[i] <= x_q[i-1];
            end
`ifdef W_FOLD_BANK_SWAP_EN
            // Write targets the pre-swap shadow, which becomes live on a swap.
            if (wr_ok)   w_q[!bank_q][update_idx] <= update_data;
            if (do_swap) bank_q <= !bank_q;
            pend_q <= (pend_q || swap_in) && !do_swap;
`else
            if (wr_ok) w_q[update_idx] <= update_data;
`endif
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sat_out   = sat_q;

endmodule
